dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 43 ++++
 rtl/dmem_lane_align.sv | 74 +++++++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: load/store size codes,
// FSM state encoding, byte-lane strobe patterns and the access legality check.
package dmem_arbiter_pkg;

  // funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // byte-lane write strobes
  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // 1 when the access is misaligned or its funct3 is not legal for its
  // direction (stores have no unsigned forms).
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = a[0];
      F3_W:    e = (a != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling for the data-memory arbiter.
// Store side: strobes by size/address, store data replicated into all lanes.
// Load side: byte/half selected by address, sign- or zero-extended by funct3.
// Ports:
//   i_st_funct3/i_st_addr/i_st_wdata -> o_st_strb, o_st_wdata
//   i_ld_funct3/i_ld_addr/i_ld_word  -> o_ld_data
module dmem_lane_align
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        i_st_funct3,
  input  logic [1:0]        i_st_addr,
  input  logic [DATA_W-1:0] i_st_wdata,
  output logic [3:0]        o_st_strb,
  output logic [DATA_W-1:0] o_st_wdata,
  input  logic [2:0]        i_ld_funct3,
  input  logic [1:0]        i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_word,
  output logic [DATA_W-1:0] o_ld_data
);

  localparam int unsigned LANE_W = DATA_W / 4;
  localparam int unsigned HALF_W = DATA_W / 2;

  logic [LANE_W-1:0] w_st_byte;
  logic [HALF_W-1:0] w_st_half;
  logic [DATA_W-1:0] w_ld_shifted;
  logic [LANE_W-1:0] w_ld_byte;
  logic [HALF_W-1:0] w_ld_half;

  always_comb begin
    w_st_byte  = i_st_wdata[LANE_W-1:0];
    w_st_half  = i_st_wdata[HALF_W-1:0];
    o_st_strb  = STRB_NONE;
    o_st_wdata = '0;
    case (i_st_funct3)
      F3_B: begin
        o_st_strb  = STRB_BYTE0 << i_st_addr;
        o_st_wdata = {4{w_st_byte}};
      end
      F3_H: begin
        o_st_strb  = i_st_addr[1] ? STRB_HALF_HI : STRB_HALF_LO;
        o_st_wdata = {2{w_st_half}};
      end
      F3_W: begin
        o_st_strb  = STRB_WORD;
        o_st_wdata = i_st_wdata;
      end
      default: begin
        o_st_strb  = STRB_NONE;
        o_st_wdata = '0;
      end
    endcase
  end

  // Shifting the word down by the byte offset puts the addressed byte or
  // (aligned) half in the low bits for every size.
  always_comb begin
    w_ld_shifted = i_ld_word >> (32'(i_ld_addr) * LANE_W);
    w_ld_byte    = w_ld_shifted[LANE_W-1:0];
    w_ld_half    = w_ld_shifted[HALF_W-1:0];
    o_ld_data    = '0;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{(DATA_W-LANE_W){w_ld_byte[LANE_W-1]}}, w_ld_byte};
      F3_H:    o_ld_data = {{(DATA_W-HALF_W){w_ld_half[HALF_W-1]}}, w_ld_half};
      F3_W:    o_ld_data = i_ld_word;
      F3_BU:   o_ld_data = {{(DATA_W-LANE_W){1'b0}}, w_ld_byte};
      F3_HU:   o_ld_data = {{(DATA_W-HALF_W){1'b0}}, w_ld_half};
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (p0 = core LSU, p1 = DMA) in front of a
// single-ported word memory with one-cycle read latency.
// Round-robin grant in IDLE; stores complete in the grant cycle, loads return
// two cycles after grant, misaligned/illegal accesses return err one cycle
// after grant without touching memory.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pX_req/we/addr/wdata/funct3  request side of port X
//   pX_gnt/rvalid/rdata/err      response side of port X
//   mem_addr/wdata/we/re, mem_rdata  memory interface
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_prio_p1;
  logic                  r_port;
  logic                  r_we;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rword;

  logic                  w_idle_gnt;
  logic                  w_sel_p1;
  logic                  w_we;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [2:0]            w_f3;
  logic                  w_err;
  logic [3:0]            w_st_strb;
  logic [DATA_W-1:0]     w_st_wdata;
  logic [DATA_W-1:0]     w_ld_data;
  logic [DATA_W-1:0]     w_resp_data;

  // Grant is qualified by rst_n so a request held during reset cannot pulse
  // gnt while the state register is forced to IDLE.
  assign w_idle_gnt = rst_n && (r_state == ST_IDLE) && (p0_req || p1_req);
  assign w_sel_p1   = p1_req && (!p0_req || r_prio_p1);

  assign w_we    = w_sel_p1 ? p1_we     : p0_we;
  assign w_addr  = w_sel_p1 ? p1_addr   : p0_addr;
  assign w_wdata = w_sel_p1 ? p1_wdata  : p0_wdata;
  assign w_f3    = w_sel_p1 ? p1_funct3 : p0_funct3;
  assign w_err   = access_err(w_we, w_f3, w_addr[1:0]);

  dmem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .i_st_funct3(w_f3),
    .i_st_addr  (w_addr[1:0]),
    .i_st_wdata (w_wdata),
    .o_st_strb  (w_st_strb),
    .o_st_wdata (w_st_wdata),
    .i_ld_funct3(r_funct3),
    .i_ld_addr  (r_addr[1:0]),
    .i_ld_word  (r_rword),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_gnt) begin
          if (w_err)      w_state_nxt = ST_RESP;
          else if (!w_we) w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: w_state_nxt = ST_RESP;
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_p1 <= 1'b0;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= '0;
      r_err     <= 1'b0;
      r_rword   <= '0;
    end else begin
      if (w_idle_gnt) begin
        r_prio_p1 <= !w_sel_p1;
        r_port    <= w_sel_p1;
        r_we      <= w_we;
        r_addr    <= w_addr;
        r_wdata   <= w_st_wdata;
        r_funct3  <= w_f3;
        r_err     <= w_err;
      end
      if ((r_state == ST_RD_WAIT) && !r_we) r_rword <= mem_rdata;
    end
  end

  assign w_resp_data = (r_err || r_we) ? '0 : w_ld_data;

  // Outside a memory-touching grant the address/data buses hold the last
  // latched values; only the strobes are forced low.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    mem_we    = STRB_NONE;
    mem_re    = 1'b0;
    mem_addr  = {r_addr[DM_ADDRESS-1:2], 2'b00};
    mem_wdata = r_wdata;
    if (w_idle_gnt) begin
      p0_gnt = !w_sel_p1;
      p1_gnt = w_sel_p1;
      if (!w_err) begin
        mem_addr = {w_addr[DM_ADDRESS-1:2], 2'b00};
        if (w_we) begin
          mem_we    = w_st_strb;
          mem_wdata = w_st_wdata;
        end else begin
          mem_re = 1'b1;
        end
      end
    end
    if (r_state == ST_RESP) begin
      if (r_port) begin
        p1_rvalid = 1'b1;
        p1_err    = r_err;
        p1_rdata  = w_resp_data;
      end else begin
        p0_rvalid = 1'b1;
        p0_err    = r_err;
        p0_rdata  = w_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [2:0]  p0_funct3, p1_funct3;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_funct3(p0_funct3), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_funct3(p1_funct3), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gnt_of(input int p);
    return 32'(p != 0 ? p1_gnt : p0_gnt);
  endfunction
  function automatic logic [31:0] rv_of(input int p);
    return 32'(p != 0 ? p1_rvalid : p0_rvalid);
  endfunction
  function automatic logic [31:0] err_of(input int p);
    return 32'(p != 0 ? p1_err : p0_err);
  endfunction
  function automatic logic [31:0] rd_of(input int p);
    return p != 0 ? p1_rdata : p0_rdata;
  endfunction

  task automatic set_req(input int p, input logic we, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
    if (p != 0) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_funct3 = f3;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_funct3 = f3;
    end
  endtask

  task automatic clr_req();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  // Load: grant cycle, wait cycle (memory word presented), response cycle.
  task automatic do_load(input int p, input logic [8:0] addr, input logic [2:0] f3,
                         input logic [31:0] word, input logic [31:0] exp_data,
                         input logic [8:0] exp_maddr);
    @(negedge clk);
    set_req(p, 1'b0, addr, 32'h0, f3);
    mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("ld_gnt", gnt_of(p), 32'd1);
    chk("ld_gnt_other", gnt_of(1 - p), 32'd0);
    chk("ld_mem_re", 32'(mem_re), 32'd1);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_addr", 32'(mem_addr), 32'(exp_maddr));
    @(negedge clk);
    clr_req();
    mem_rdata = word;
    #1;
    chk("ld_wait_rvalid", rv_of(p), 32'd0);
    chk("ld_wait_mem_re", 32'(mem_re), 32'd0);
    @(negedge clk);
    mem_rdata = 32'hA5A50000;
    #1;
    chk("ld_rvalid", rv_of(p), 32'd1);
    chk("ld_rdata", rd_of(p), exp_data);
    chk("ld_err", err_of(p), 32'd0);
    chk("ld_rvalid_other", rv_of(1 - p), 32'd0);
    chk("ld_rdata_other", rd_of(1 - p), 32'd0);
  endtask

  task automatic do_store(input int p, input logic [8:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wd, input logic [8:0] exp_maddr);
    @(negedge clk);
    set_req(p, 1'b1, addr, wd, f3);
    #1;
    chk("st_gnt", gnt_of(p), 32'd1);
    chk("st_gnt_other", gnt_of(1 - p), 32'd0);
    chk("st_mem_we", 32'(mem_we), 32'(exp_strb));
    chk("st_mem_wdata", mem_wdata, exp_wd);
    chk("st_mem_addr", 32'(mem_addr), 32'(exp_maddr));
    chk("st_mem_re", 32'(mem_re), 32'd0);
    @(negedge clk);
    clr_req();
    #1;
    chk("st_no_rvalid0", 32'(p0_rvalid), 32'd0);
    chk("st_no_rvalid1", 32'(p1_rvalid), 32'd0);
    chk("st_after_mem_we", 32'(mem_we), 32'd0);
  endtask

  task automatic do_err(input int p, input logic we, input logic [8:0] addr,
                        input logic [2:0] f3);
    @(negedge clk);
    set_req(p, we, addr, 32'hFFFFFFFF, f3);
    #1;
    chk("er_gnt", gnt_of(p), 32'd1);
    chk("er_mem_re", 32'(mem_re), 32'd0);
    chk("er_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    clr_req();
    #1;
    chk("er_rvalid", rv_of(p), 32'd1);
    chk("er_err", err_of(p), 32'd1);
    chk("er_rdata", rd_of(p), 32'd0);
    chk("er_rvalid_other", rv_of(1 - p), 32'd0);
    @(negedge clk);
    #1;
    chk("er_done_rvalid", rv_of(p), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_funct3 = 3'b010;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_funct3 = 3'b010;
    mem_rdata = '0;

    // reset state, with a request held during reset
    @(negedge clk);
    #1;
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // directed load/store vectors
    do_load (0, 9'h010, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 9'h010);
    do_store(1, 9'h013, 3'b000, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 9'h010);
    do_load (0, 9'h011, 3'b000, 32'h00008000, 32'hFFFFFF80, 9'h010);
    do_load (1, 9'h011, 3'b100, 32'h00008000, 32'h00000080, 9'h010);
    do_load (0, 9'h012, 3'b001, 32'h80010000, 32'hFFFF8001, 9'h010);
    do_load (1, 9'h012, 3'b101, 32'h80010000, 32'h00008001, 9'h010);
    do_load (0, 9'h003, 3'b000, 32'h7F000000, 32'h0000007F, 9'h000);
    do_store(0, 9'h002, 3'b001, 32'h00001234, 4'b1100, 32'h12341234, 9'h000);
    do_store(1, 9'h1FC, 3'b010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 9'h1FC);
    do_store(0, 9'h001, 3'b000, 32'hFFFFFF3C, 4'b0010, 32'h3C3C3C3C, 9'h000);

    // misaligned / illegal
    do_err(0, 1'b0, 9'h021, 3'b001);
    do_err(1, 1'b1, 9'h006, 3'b010);
    do_err(0, 1'b0, 9'h000, 3'b011);
    do_err(1, 1'b1, 9'h000, 3'b100);

    // requests during RD_WAIT/RESP must wait for IDLE
    @(negedge clk);
    set_req(0, 1'b0, 9'h008, 32'h0, 3'b010);
    mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("wt_p0_gnt", 32'(p0_gnt), 32'd1);
    @(negedge clk);
    p0_req = 1'b0;
    set_req(1, 1'b1, 9'h00C, 32'h55667788, 3'b010);
    mem_rdata = 32'h11223344;
    #1;
    chk("wt_rdwait_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("wt_rdwait_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    #1;
    chk("wt_resp_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("wt_resp_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("wt_resp_p0_rdata", p0_rdata, 32'h11223344);
    @(negedge clk);
    #1;
    chk("wt_idle_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("wt_idle_mem_we", 32'(mem_we), 32'hF);
    clr_req();

    // round robin from reset with both ports requesting continuously
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 9'h000, 32'h01010101, 3'b010);
    set_req(1, 1'b1, 9'h004, 32'h02020202, 3'b010);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_p0_gnt", 32'(p0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_p1_gnt", 32'(p1_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_not_both", 32'(p0_gnt & p1_gnt), 32'd0);
      @(negedge clk);
    end
    clr_req();

    // reset during RD_WAIT abandons the load
    @(negedge clk);
    set_req(0, 1'b0, 9'h010, 32'h0, 3'b010);
    #1;
    chk("rw_gnt", 32'(p0_gnt), 32'd1);
    @(negedge clk);
    clr_req();
    p1_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rw_rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rw_rst_mem_re", 32'(mem_re), 32'd0);
    chk("rw_rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rw_rst_p0_rdata", p0_rdata, 32'd0);
    @(negedge clk);
    p1_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rw_post_p0_rvalid", 32'(p0_rvalid), 32'd0);
      chk("rw_post_p1_rvalid", 32'(p1_rvalid), 32'd0);
      @(negedge clk);
    end

    // reset during RESP drops rvalid immediately
    set_req(1, 1'b0, 9'h014, 32'h0, 3'b010);
    #1;
    chk("rr2_gnt", 32'(p1_gnt), 32'd1);
    @(negedge clk);
    clr_req();
    mem_rdata = 32'h87654321;
    @(negedge clk);
    #1;
    chk("rr2_resp_rvalid", 32'(p1_rvalid), 32'd1);
    chk("rr2_resp_rdata", p1_rdata, 32'h87654321);
    rst_n = 1'b0;
    #1;
    chk("rr2_rst_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rr2_rst_rdata", p1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rr2_post_rvalid", 32'(p1_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
